cond_select_sequencer: RTL and testbench
========================================

// Module: cond_select_sequencer
// PURPOSE
//  Sequences a registered 2:1 conditional-select unit (selector bit 0 picks in1 over in2, latency 1).
//  Generates a periodic selector pattern plus a qualifying enable for a programmed number of iterations.
//  The pattern follows an optional start delay, and the sequencer flags completion once the last selected word has left the unit.
//  It sits in the accelerator datapath between the configuration bus and the select unit's selector input.
// PARAMETERS
//  DELAY_W  32  width of start-delay counter/config
//  CNT_W    16  width of period, duty and iteration counters/config
// PORTS
//  clk          in   1        clock, all logic on rising edge
//  rst          in   1        synchronous reset, active-high
//  running      in   1        accelerator active; low aborts any sequence
//  run          in   1        start pulse (1 cycle), sampled only when running=1
//  cfg_delay    in   DELAY_W  cycles to wait after run before first selector
//  cfg_period   in   CNT_W    pattern period in cycles (0 treated as 1)
//  cfg_duty     in   CNT_W    cycles per period with selector=1 (>=period -> always 1)
//  cfg_iter     in   CNT_W    total selector cycles to emit
//  sel_out      out  32       selector word; bit0 = pattern, bits[31:1]=0
//  sel_valid    out  1        sel_out is a live selector this cycle
//  busy         out  1        high in DELAY/ACTIVE/DRAIN
//  done         out  1        sequence complete, held until next accepted run
// BEHAVIOUR
//  - Reset: state=IDLE; sel_out=0, sel_valid=0, busy=0, done=0; all counters 0.
//  - States: IDLE, DELAY, ACTIVE, DRAIN, DONE (encoded in shared package).
//  - Accept: run&running in IDLE or DONE -> cfg_* latched into shadow regs, done<=0, next state:
//      cfg_iter==0 -> DONE (done=1 next cycle, no sel_valid); cfg_delay!=0 -> DELAY; else ACTIVE.
//  - run in DELAY/ACTIVE/DRAIN ignored; cfg_* changes after accept ignored.
//  - DELAY: down-count shadow delay; exactly cfg_delay cycles in DELAY, then ACTIVE.
//  - Latency: delay=0 -> sel_valid first high the cycle after run is sampled; delay=D -> D cycles later.
//  - ACTIVE: sel_valid=1; sel_out[0]=(phase<duty); phase++ and wraps to 0 at period-1;
//      iteration counter decrements per cycle; after the cfg_iter-th cycle -> DRAIN.
//  - DRAIN: 1 cycle (covers the select unit's registered output), sel_valid=0 -> DONE.
//  - DONE: done=1, busy=0; held until next accepted run or abort.
//  - Abort: running=0 in any state -> IDLE next cycle; sel_valid, busy, done cleared.
//  - Counters saturate-free: phase compares unsigned CNT_W; period=0 behaves as period=1.
//  - sel_out holds last value when sel_valid=0 (cleared only by reset/abort).
// CONFIGURATION
//  COND_SEQ_STATS_EN defined: adds output stat_ones [CNT_W] = count of ACTIVE cycles with
//    sel_out[0]=1 in the current/last sequence; cleared on accept, on abort and on reset; frozen in DONE.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - Package cond_seq_pkg: state enum (IDLE, DELAY, ACTIVE, DRAIN, DONE), localparam DRAIN_CYCLES=1.
//  - Sub-module cond_pattern_gen: phase counter + duty compare (inputs period, duty, step, clear).
//  - Top: FSM, shadow config regs, delay/iteration counters, optional stats counter.
// TESTING
//  1 rst=1 two cycles, then idle -> all outputs 0; run with running=0 -> no state change.
//  2 delay=0, period=4, duty=1, iter=8 -> sel_out[0] = 1,0,0,0,1,0,0,0 on cycles t+1..t+8;
//    done=1 at t+10; stat_ones=2 (STATS_EN).
//  3 delay=3, period=2, duty=5, iter=3 -> sel_valid first at t+4, sel always 1, done at t+8.
//  4 iter=0 -> sel_valid never asserts, done=1 at t+1; period=0, duty=0, iter=3 -> sel=0,0,0.
//  5 running dropped mid-ACTIVE -> next cycle IDLE, sel_valid=0, done=0; restart works normally.
//  6 run re-pulsed during ACTIVE ignored; run in DONE with new cfg -> done clears, new pattern.

Source files
------------

// File: rtl/cond_seq_pkg.sv
// Shared definitions for the conditional-select sequencer: state encoding and drain length.
// Optional build macro COND_SEQ_STATS_EN is consumed by cond_select_sequencer, not here.
package cond_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_DELAY  = 3'd1;
    localparam state_t S_ACTIVE = 3'd2;
    localparam state_t S_DRAIN  = 3'd3;
    localparam state_t S_DONE   = 3'd4;

    // The select unit registers its output once, so one idle cycle flushes it.
    localparam int DRAIN_CYCLES = 1;

endpackage

// File: rtl/cond_pattern_gen.sv
// Periodic selector pattern: a phase counter wrapping at period-1, pattern = (phase < duty).
// A period of 0 behaves as a period of 1 (phase stays at 0).
module cond_pattern_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_duty,
    input  logic             i_step,
    input  logic             i_clear,
    output logic             o_pattern
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_phase;
    logic             w_wrap;

    assign w_wrap    = (i_period <= CNT_ONE) || (r_phase == (i_period - CNT_ONE));
    assign o_pattern = (r_phase < i_duty);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_phase <= '0;
        end else if (i_step) begin
            r_phase <= w_wrap ? '0 : (r_phase + CNT_ONE);
        end
    end

endmodule

// File: rtl/cond_select_sequencer.sv
// Drives the selector/enable of a registered 2:1 select unit for a programmed number of cycles.
// Define COND_SEQ_STATS_EN to add the stat_ones output (count of selector=1 cycles in the sequence).
module cond_select_sequencer
    import cond_seq_pkg::*;
#(
    parameter int DELAY_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               running,
    input  logic               run,
    input  logic [DELAY_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_duty,
    input  logic [CNT_W-1:0]   cfg_iter,
    output logic [31:0]        sel_out,
    output logic               sel_valid,
    output logic               busy,
    output logic               done
`ifdef COND_SEQ_STATS_EN
    ,
    output logic [CNT_W-1:0]   stat_ones
`endif
);

    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [DELAY_W-1:0] DELAY_ONE = DELAY_W'(1);
    localparam logic [3:0]         DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

    state_t             r_state;
    logic [DELAY_W-1:0] r_delay_cnt;
    logic [CNT_W-1:0]   r_iter_cnt;
    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   r_duty;
    logic [3:0]         r_drain_cnt;
    logic               r_sel_hold;

    logic w_accept;
    logic w_active;
    logic w_pattern;

    assign w_accept = running && run && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_active = (r_state == S_ACTIVE);

    cond_pattern_gen #(
        .CNT_W (CNT_W)
    ) u_pattern (
        .clk       (clk),
        .rst       (rst),
        .i_period  (r_period),
        .i_duty    (r_duty),
        .i_step    (w_active && running),
        .i_clear   (w_accept || !running),
        .o_pattern (w_pattern)
    );

    always_ff @(posedge clk) begin
        if (rst || !running) begin
            r_state     <= S_IDLE;
            r_delay_cnt <= '0;
            r_iter_cnt  <= '0;
            r_period    <= '0;
            r_duty      <= '0;
            r_drain_cnt <= '0;
            r_sel_hold  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (run) begin
                        r_delay_cnt <= cfg_delay;
                        r_iter_cnt  <= cfg_iter;
                        r_period    <= cfg_period;
                        r_duty      <= cfg_duty;
                        if (cfg_iter == '0)
                            r_state <= S_DONE;
                        else if (cfg_delay != '0)
                            r_state <= S_DELAY;
                        else
                            r_state <= S_ACTIVE;
                    end
                end
                S_DELAY: begin
                    r_delay_cnt <= r_delay_cnt - DELAY_ONE;
                    if (r_delay_cnt == DELAY_ONE)
                        r_state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    // Remember the emitted bit so sel_out holds once sel_valid drops.
                    r_sel_hold <= w_pattern;
                    r_iter_cnt <= r_iter_cnt - CNT_ONE;
                    if (r_iter_cnt == CNT_ONE) begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= DRAIN_INIT;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == '0)
                        r_state <= S_DONE;
                    else
                        r_drain_cnt <= r_drain_cnt - 4'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef COND_SEQ_STATS_EN
    logic [CNT_W-1:0] r_stat_ones;

    always_ff @(posedge clk) begin
        if (rst || !running || w_accept)
            r_stat_ones <= '0;
        else if (w_active && w_pattern)
            r_stat_ones <= r_stat_ones + CNT_ONE;
    end

    assign stat_ones = r_stat_ones;
`endif

    assign sel_valid = w_active;
    assign sel_out   = {31'b0, (w_active ? w_pattern : r_sel_hold)};
    assign busy      = (r_state == S_DELAY) || w_active || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_cond_select_sequencer.sv
// Self-checking bench for cond_select_sequencer; honours COND_SEQ_STATS_EN when defined.
module tb_cond_select_sequencer;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          running;
    logic          run;
    logic [DW-1:0] cfg_delay;
    logic [CW-1:0] cfg_period;
    logic [CW-1:0] cfg_duty;
    logic [CW-1:0] cfg_iter;
    logic [31:0]   sel_out;
    logic          sel_valid;
    logic          busy;
    logic          done;
`ifdef COND_SEQ_STATS_EN
    logic [CW-1:0] stat_ones;
`endif

    cond_select_sequencer #(.DELAY_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .running    (running),
        .run        (run),
        .cfg_delay  (cfg_delay),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cfg_iter   (cfg_iter),
        .sel_out    (sel_out),
        .sel_valid  (sel_valid),
        .busy       (busy),
        .done       (done)
`ifdef COND_SEQ_STATS_EN
        ,
        .stat_ones  (stat_ones)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] sel;
        logic        b;
        logic        d;
    } exp_t;

    typedef struct {
        int         delay;
        int         period;
        int         duty;
        int         iter;
        logic [7:0] pat;
        int         ones;
        bit         repulse;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[7];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_sel = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input exp_t e);
        chk({tag, ".sel_valid"}, {31'b0, sel_valid}, {31'b0, e.v});
        chk({tag, ".sel_out"}, sel_out, e.sel);
        chk({tag, ".busy"}, {31'b0, busy}, {31'b0, e.b});
        chk({tag, ".done"}, {31'b0, done}, {31'b0, e.d});
    endtask

    // Called at a negedge; the run pulse is sampled by the following posedge (cycle t).
    task automatic run_vec(input int idx, input vec_t v);
        int   total;
        exp_t e;
        logic [31:0] cur;
        cfg_delay  = DW'(v.delay);
        cfg_period = CW'(v.period);
        cfg_duty   = CW'(v.duty);
        cfg_iter   = CW'(v.iter);
        run        = 1'b1;
        cur   = last_sel;
        total = (v.iter == 0) ? 1 : v.delay + v.iter + 2;
        for (int k = 1; k <= total; k++) begin
            e.v = 1'b0; e.b = 1'b1; e.d = 1'b0; e.sel = cur;
            if (v.iter == 0) begin
                e.b = 1'b0; e.d = 1'b1;
            end else if (k > v.delay && k <= v.delay + v.iter) begin
                cur   = {31'b0, v.pat[k - v.delay - 1]};
                e.v   = 1'b1;
                e.sel = cur;
            end else if (k == total) begin
                e.b = 1'b0; e.d = 1'b1;
            end
            sb.push_back(e);
        end
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("vec%0d.c%0d", idx, k), 32'd0, 32'd0 ^ 32'd0) ;
            checks--;
            chk_outputs($sformatf("vec%0d.c%0d", idx, k), e);
            run = (v.repulse && k == v.delay + 2) ? 1'b1 : 1'b0;
            if (k == 1) begin
                cfg_delay  = $urandom;
                cfg_period = CW'($urandom);
                cfg_duty   = CW'($urandom);
                cfg_iter   = CW'($urandom);
            end
        end
        last_sel = cur;
`ifdef COND_SEQ_STATS_EN
        chk($sformatf("vec%0d.stat_ones", idx), {16'b0, stat_ones}, v.ones);
`endif
        $display("vec %0d delay=%0d period=%0d duty=%0d iter=%0d cycles=%0d checked",
                 idx, v.delay, v.period, v.duty, v.iter, total);
    endtask

    initial begin
        exp_t z;
        vecs[0] = '{delay:0, period:4, duty:1, iter:8, pat:8'b0001_0001, ones:2, repulse:1'b1};
        vecs[1] = '{delay:3, period:2, duty:5, iter:3, pat:8'b0000_0111, ones:3, repulse:1'b0};
        vecs[2] = '{delay:0, period:0, duty:0, iter:3, pat:8'b0000_0000, ones:0, repulse:1'b0};
        vecs[3] = '{delay:0, period:3, duty:2, iter:7, pat:8'b0101_1011, ones:5, repulse:1'b1};
        vecs[4] = '{delay:1, period:1, duty:0, iter:2, pat:8'b0000_0000, ones:0, repulse:1'b0};
        vecs[5] = '{delay:2, period:0, duty:1, iter:2, pat:8'b0000_0011, ones:2, repulse:1'b0};
        vecs[6] = '{delay:5, period:4, duty:2, iter:0, pat:8'b0000_0000, ones:0, repulse:1'b0};

        rst = 1'b1; running = 1'b0; run = 1'b0;
        cfg_delay = '0; cfg_period = '0; cfg_duty = '0; cfg_iter = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        z = '{v:1'b0, sel:32'd0, b:1'b0, d:1'b0};
        chk_outputs("reset", z);
`ifdef COND_SEQ_STATS_EN
        chk("reset.stat_ones", {16'b0, stat_ones}, 32'd0);
`endif
        $display("reset: outputs checked after 2 reset cycles");

        // run while not running must not start anything
        cfg_iter = 16'd4; run = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk_outputs($sformatf("norun.c%0d", k), z);
        end
        run = 1'b0;
        running = 1'b1;
        @(negedge clk);
        chk_outputs("idle", z);
        $display("run with running=0: no state change");

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // abort mid-ACTIVE: delay 0, period 2, duty 1 -> 1,0,1 then drop running
        cfg_delay = '0; cfg_period = 16'd2; cfg_duty = 16'd1; cfg_iter = 16'd10;
        run = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            run = 1'b0;
            chk_outputs($sformatf("abort.c%0d", k),
                        '{v:1'b1, sel:{31'b0, (k % 2 == 1)}, b:1'b1, d:1'b0});
        end
        running = 1'b0;
        @(negedge clk);
        chk_outputs("abort.idle", z);
`ifdef COND_SEQ_STATS_EN
        chk("abort.stat_ones", {16'b0, stat_ones}, 32'd0);
`endif
        running = 1'b1;
        @(negedge clk);
        chk_outputs("abort.stay", z);
        last_sel = 32'd0;
        $display("abort mid-ACTIVE: returned to idle");

        run_vec(7, vecs[3]);
        run_vec(8, vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
